// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
package seg7_pkg;

  localparam logic [3:0] REG_CTRL      = 4'd8;
  localparam logic [3:0] REG_BRIGHT    = 4'd9;
  localparam logic [3:0] REG_BLINKMASK = 4'd10;
  localparam logic [3:0] REG_STATUS    = 4'd11;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_DECODE   = 1;
  localparam int unsigned CTRL_BLINK_EN = 2;
  localparam int unsigned CTRL_IRQ_EN   = 3;

  typedef struct packed {
    logic irq_en;
    logic blink_en;
    logic decode;
    logic en;
  } ctrl_t;

  // Hex glyphs, active-high, bit0 = a .. bit6 = g
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hexdec.sv
// Combinational nibble to 7-segment glyph decoder (active-high).
module seg7_hexdec
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  // Table lookup of the glyph
  always_comb seg_c = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan.sv
// Bus-mapped multiplexed 7-segment driver with PWM brightness, blink and frame irq.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned OSC_CLOCK      = 12000000,
  parameter int unsigned REFRESH_CLOCK  = 50,
  parameter int unsigned DIGITS         = 2,
  parameter int unsigned BLINK_FRAMES   = 25,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        AD,
  input  logic [7:0]        DI,
  output logic [7:0]        DO,
  input  logic              rw,
  input  logic              cs,
  output logic              irq,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] anode
);

  localparam int unsigned TICK   = OSC_CLOCK / (REFRESH_CLOCK * DIGITS * 16);
  localparam int unsigned TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int unsigned BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0]        SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Reject clock ratios too small for one clk per PWM step, and bad digit counts
  if (TICK < 1 || DIGITS < 1 || DIGITS > 8) begin : g_param_check
    $error("seg7_scan: TICK must be >= 1 and DIGITS in 1..8");
  end

  logic [7:0]        digit_q [8];
  ctrl_t             ctrl_q;
  logic [3:0]        bright_q;
  logic [7:0]        mask_q;
  logic              flag_q;
  logic [TICK_W-1:0] tick_q;
  logic [3:0]        phase_q;
  logic [2:0]        idx_q;
  logic [BLK_W-1:0]  blink_cnt_q;
  logic              blink_ph_q;
  logic [7:0]        slot_q;

  logic              wr_c;
  logic              tick_wrap_c;
  logic              slot_end_c;
  logic              frame_end_c;
  logic              slot_start_c;
  logic              lit_c;
  logic              flag_nxt_c;
  logic              irq_en_nxt_c;
  logic [7:0]        cur_dig_c;
  logic [7:0]        pat_c;
  logic [6:0]        hex_c;
  logic [DIGITS-1:0] an_sel_c;

  seg7_hexdec u_hexdec (
    .nib   (cur_dig_c[3:0]),
    .seg_c (hex_c)
  );

  // Scan sequencing, slot latch, lit decision and next flag/irq
  always_comb begin
    wr_c         = cs & ~rw;
    tick_wrap_c  = ctrl_q.en & (tick_q == TICK_W'(TICK - 1));
    slot_end_c   = tick_wrap_c & (phase_q == 4'd15);
    frame_end_c  = slot_end_c & (idx_q == 3'(DIGITS - 1));
    slot_start_c = (tick_q == '0) & (phase_q == 4'd0);
    // Digit value is sampled only at slot start so a mid-slot write cannot tear
    cur_dig_c    = slot_start_c ? digit_q[idx_q] : slot_q;
    pat_c        = ctrl_q.decode ? {cur_dig_c[7], hex_c} : cur_dig_c;
    lit_c        = ctrl_q.en & (phase_q <= bright_q) &
                   ~(ctrl_q.blink_en & blink_ph_q & mask_q[idx_q]);
    flag_nxt_c   = flag_q;
    if (wr_c && AD == REG_STATUS && DI[0]) flag_nxt_c = 1'b0;
    if (frame_end_c) flag_nxt_c = 1'b1;
    irq_en_nxt_c = (wr_c && AD == REG_CTRL) ? DI[CTRL_IRQ_EN] : ctrl_q.irq_en;
    an_sel_c     = '0;
    for (int i = 0; i < int'(DIGITS); i++) an_sel_c[i] = (idx_q == 3'(i));
  end

  // Combinational register read port
  always_comb begin
    DO = 8'hFF;
    if (cs) begin
      if (AD < 4'(DIGITS)) begin
        DO = digit_q[AD[2:0]];
      end else begin
        case (AD)
          REG_CTRL:      DO = {4'h0, ctrl_q};
          REG_BRIGHT:    DO = {4'h0, bright_q};
          REG_BLINKMASK: DO = mask_q;
          REG_STATUS:    DO = {1'b0, idx_q, blink_ph_q, 2'b00, flag_q};
          default:       DO = 8'hFF;
        endcase
      end
    end
  end

  // CPU-writable configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) digit_q[i] <= 8'h00;
      ctrl_q   <= '0;
      bright_q <= 4'hF;
      mask_q   <= 8'h00;
    end else if (wr_c) begin
      if (AD < 4'(DIGITS)) digit_q[AD[2:0]] <= DI;
      case (AD)
        REG_CTRL: ctrl_q <= '{irq_en:   DI[CTRL_IRQ_EN],
                              blink_en: DI[CTRL_BLINK_EN],
                              decode:   DI[CTRL_DECODE],
                              en:       DI[CTRL_EN]};
        REG_BRIGHT:    bright_q <= DI[3:0];
        REG_BLINKMASK: mask_q   <= DI;
        default: ;
      endcase
    end
  end

  // Tick/phase/digit/blink counters, frame flag and slot latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q      <= '0;
      phase_q     <= 4'd0;
      idx_q       <= 3'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      flag_q      <= 1'b0;
      slot_q      <= 8'h00;
    end else begin
      flag_q <= flag_nxt_c;
      slot_q <= cur_dig_c;
      if (ctrl_q.en) begin
        tick_q <= tick_wrap_c ? '0 : tick_q + TICK_W'(1);
        if (tick_wrap_c) phase_q <= phase_q + 4'd1;
        if (slot_end_c) idx_q <= frame_end_c ? 3'd0 : idx_q + 3'd1;
        if (frame_end_c) begin
          if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_q <= '0;
            blink_ph_q  <= ~blink_ph_q;
          end else begin
            blink_cnt_q <= blink_cnt_q + BLK_W'(1);
          end
        end
      end
    end
  end

  // Registered pin drivers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode <= AN_OFF;
      seg   <= SEG_OFF;
      irq   <= 1'b0;
    end else begin
      irq <= flag_nxt_c & irq_en_nxt_c;
      if (lit_c) begin
        anode <= AN_ACTIVE_LOW ? ~an_sel_c : an_sel_c;
        seg   <= SEG_ACTIVE_LOW ? ~pat_c : pat_c;
      end else begin
        anode <= AN_OFF;
        seg   <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: scoreboarded scan outputs plus directed register checks.
module tb_seg7_scan;

  localparam int unsigned DIGITS       = 4;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam logic [6:0] HEX_TAB [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
  } out_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [3:0]        AD  = 4'd0;
  logic [7:0]        DI  = 8'h00;
  logic [7:0]        DO;
  logic              rw  = 1'b1;
  logic              cs  = 1'b0;
  logic              irq;
  logic [7:0]        seg;
  logic [DIGITS-1:0] anode;

  seg7_scan #(
    .OSC_CLOCK      (3200),
    .REFRESH_CLOCK  (50),
    .DIGITS         (DIGITS),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .AD    (AD),
    .DI    (DI),
    .DO    (DO),
    .rw    (rw),
    .cs    (cs),
    .irq   (irq),
    .seg   (seg),
    .anode (anode)
  );

  always #5 clk = ~clk;

  // Bench model of register file and scan position
  logic [7:0] m_dig [4];
  logic [3:0] m_ctrl;
  logic [3:0] m_bright;
  logic [7:0] m_mask;
  logic       m_flag;
  logic [7:0] m_slot;
  int         m_n;
  int         m_fe;
  out_t       exp_q [$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_idx();
    return (m_n / 16) % DIGITS;
  endfunction

  function automatic int m_blink();
    return (m_fe / BLINK_FRAMES) % 2;
  endfunction

  function automatic logic [7:0] m_status();
    return {1'b0, 3'(m_idx()), m_blink() == 1, 2'b00, m_flag};
  endfunction

  function automatic out_t model_out();
    out_t       o;
    logic [7:0] pat;
    int         idx;
    idx   = m_idx();
    o.an  = '0;
    o.seg = 8'hFF;
    if (m_ctrl[0] && (m_n % 16) <= int'(m_bright) &&
        !(m_ctrl[2] && m_blink() == 1 && m_mask[idx])) begin
      pat   = m_ctrl[1] ? {m_slot[7], HEX_TAB[m_slot[3:0]]} : m_slot;
      o.an  = DIGITS'(1) << idx;
      o.seg = ~pat;
    end
    return o;
  endfunction

  // One clock: advance model, compare previous expectation, queue the next
  task automatic tick();
    logic       wv;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       en_b;
    logic       fe;
    out_t       e;
    wv   = cs && !rw;
    wa   = AD;
    wd   = DI;
    en_b = m_ctrl[0];
    @(posedge clk);
    #1;
    fe = 1'b0;
    if (en_b) begin
      m_n++;
      if (m_n % (16 * DIGITS) == 0) begin
        fe = 1'b1;
        m_fe++;
      end
    end
    if (wv) begin
      if (wa < 4'(DIGITS)) m_dig[wa[1:0]] = wd;
      else begin
        case (wa)
          4'd8:  m_ctrl   = wd[3:0];
          4'd9:  m_bright = wd[3:0];
          4'd10: m_mask   = wd;
          4'd11: if (wd[0]) m_flag = 1'b0;
          default: ;
        endcase
      end
    end
    if (fe) m_flag = 1'b1;
    if (m_n % 16 == 0) m_slot = m_dig[2'(m_idx())];
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("anode", 32'(anode), 32'(e.an));
      chk("seg", 32'(seg), 32'(e.seg));
    end
    chk("irq", 32'(irq), 32'(m_flag & m_ctrl[3]));
    exp_q.push_back(model_out());
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; AD = a; DI = d;
    tick();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    cs = 1'b1; rw = 1'b1; AD = a;
    #1;
    chk(tag, 32'(DO), 32'(exp));
    cs = 1'b0;
    tick();
  endtask

  task automatic seek(input int idx, input int ph, input int blk, input int limit);
    int k;
    k = 0;
    while (!(m_idx() == idx && m_n % 16 == ph && (blk < 0 || m_blink() == blk)) && k < limit) begin
      tick();
      k++;
    end
    chk("seek_bound", 32'(k < limit), 32'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_anode", 32'(anode), 32'(0));
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_irq", 32'(irq), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = 8'h00;
    m_ctrl = 4'h0; m_bright = 4'hF; m_mask = 8'h00; m_flag = 1'b0;
    m_slot = 8'h00; m_n = 0; m_fe = 0;
    exp_q.delete();
  endtask

  task automatic read_reset_values();
    chk("do_idle", 32'(DO), 32'hFF);
    for (int i = 0; i < 4; i++) rd("rst_digit", 4'(i), 8'h00);
    rd("rst_ctrl", 4'd8, 8'h00);
    rd("rst_bright", 4'd9, 8'h0F);
    rd("rst_mask", 4'd10, 8'h00);
    rd("rst_status", 4'd11, 8'h00);
    rd("rst_off12", 4'd12, 8'hFF);
    rd("rst_off5", 4'd5, 8'hFF);
  endtask

  initial begin
    #2;
    do_reset();
    read_reset_values();
    repeat (4) tick();

    // Decoded scan of four digits
    wr(4'd0, 8'h01); wr(4'd1, 8'h02); wr(4'd2, 8'h03); wr(4'd3, 8'h84);
    wr(4'd8, 8'h03);
    rd("ctrl_rb", 4'd8, 8'h03);
    repeat (128) tick();
    seek(3, 2, -1, 100);
    tick();
    chk("dig3_anode", 32'(anode), 32'h8);
    chk("dig3_seg_dp", 32'(seg), 32'(8'h19));

    // Brightness PWM
    wr(4'd9, 8'h13);
    rd("bright_rb", 4'd9, 8'h03);
    repeat (128) tick();
    seek(1, 4, -1, 100);
    tick();
    chk("dim_blank", 32'(anode), 32'(0));
    wr(4'd9, 8'h00);
    repeat (64) tick();
    wr(4'd9, 8'h0F);

    // Frame flag and irq
    wr(4'd8, 8'h0F);
    seek(1, 4, -1, 100);
    wr(4'd11, 8'h01);
    rd("status_clr", 4'd11, m_status());
    seek(3, 15, -1, 100);
    wr(4'd11, 8'h01);
    chk("irq_set_wins", 32'(irq), 32'(1));
    rd("status_set_wins", 4'd11, {1'b0, 3'd0, m_blink() == 1, 3'b001});
    repeat (10) tick();
    wr(4'd11, 8'h01);
    chk("irq_cleared", 32'(irq), 32'(0));
    rd("status_cleared", 4'd11, m_status());
    seek(0, 5, -1, 100);
    chk("irq_again", 32'(irq), 32'(1));
    wr(4'd8, 8'h07);
    chk("irq_masked", 32'(irq), 32'(0));
    rd("flag_kept", 4'd11, m_status());

    // Blink on digit 1
    wr(4'd10, 8'h02);
    repeat (512) tick();
    seek(1, 6, 1, 600);
    tick();
    chk("blink_off", 32'(anode), 32'(0));
    seek(1, 6, 0, 600);
    tick();
    chk("blink_on", 32'(anode), 32'h2);

    // Mid-slot digit write does not tear
    seek(1, 4, 0, 600);
    wr(4'd1, 8'h0E);
    tick();
    chk("no_tear", 32'(seg), 32'(8'hA4));
    repeat (80) tick();

    // Raw segment mode
    wr(4'd8, 8'h01);
    wr(4'd0, 8'h5A);
    seek(0, 3, -1, 100);
    tick();
    chk("raw_seg", 32'(seg), 32'(8'hA5));

    // EN clear holds counters and blanks
    seek(2, 7, -1, 100);
    wr(4'd8, 8'h00);
    repeat (20) tick();
    chk("hold_blank", 32'(anode), 32'(0));
    rd("hold_status", 4'd11, {1'b0, 3'd2, m_blink() == 1, 2'b00, m_flag});
    wr(4'd8, 8'h01);
    repeat (40) tick();

    // Asynchronous reset mid-slot
    wr(4'd8, 8'h09);
    seek(1, 6, -1, 100);
    chk("irq_pre_rst", 32'(irq), 32'(1));
    do_reset();
    read_reset_values();
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
